conn_table_arbiter: RTL and testbench
=====================================

CONN_TABLE_ARBITER -- requirements
Module: conn_table_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in WAIT before abort (1..65535).
REQ-002 SHALL have ports cta_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port cta_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cta_req_valid  in  2  per-requester request (bit0 = RX path, bit1 = TX path).
REQ-005 SHALL have port cta_req_op  in  4  2 bits per requester: 01 lookup, 10 insert, 11 delete, 00 illegal.
REQ-006 SHALL have port cta_req_tuple  in  288  144 bits per requester: [143:120] mac_src, [119:96] mac_dst, [95:64] ip_src, [63:32] ip_dst, [31:16] port_src, [15:0] port_dst.
REQ-007 SHALL have port cta_req_id  in  16  8 bits per requester, connection ID for delete.
REQ-008 SHALL have port cta_req_ready  out  2  one-cycle accept pulse per requester.
REQ-009 SHALL have ports cta_rsp_valid  out  2  one-cycle response pulse; cta_rsp_id  out  8; cta_rsp_error  out  8.
REQ-010 SHALL have ports cta_rs_rq  out  2; cta_rs_id  out  8; cta_rs_tuple  out  144 (same field layout as REQ-006): drive to the connection searcher.
REQ-011 SHALL have ports cta_rs_done  in  1; cta_rs_error  in  8; cta_rs_id_in  in  8: searcher result.
REQ-012 SHALL have port cta_busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any cta_req_valid bit set, SHALL grant one requester, pulse its cta_req_ready, latch its op/tuple/id, and go to ISSUE the next cycle.
REQ-015 Arbitration SHALL be round-robin: 1-bit pointer names the preferred requester; on simultaneous valid the pointer wins; after each grant the pointer moves to the non-granted requester.
REQ-016 A single valid requester SHALL be granted regardless of pointer.
REQ-017 ISSUE: SHALL drive cta_rs_rq = latched op for exactly one cycle with cta_rs_tuple/cta_rs_id stable, then go to WAIT; cta_rs_rq SHALL be 00 in all other cycles.
REQ-018 Latched op 00 SHALL skip ISSUE/WAIT and go directly to RESP with error 8'hFE, id 8'h00.
REQ-019 cta_rs_tuple and cta_rs_id SHALL hold latched values from ISSUE until return to IDLE.
REQ-020 WAIT: on cta_rs_done SHALL capture cta_rs_id_in and cta_rs_error and go to RESP.
REQ-021 WAIT: 16-bit cycle counter SHALL clear on entry; if it reaches TIMEOUT without cta_rs_done, SHALL go to RESP with error 8'hFF, id 8'h00.
REQ-022 cta_rs_done in a cycle when not in WAIT SHALL be ignored.
REQ-023 RESP: SHALL pulse cta_rsp_valid for the granted requester only, one cycle, with cta_rsp_id/cta_rsp_error valid that cycle, then return to IDLE.
REQ-024 cta_rsp_id/cta_rsp_error SHALL hold last values outside RESP.
REQ-025 No new grant SHALL occur while busy; request latency from grant to cta_rsp_valid = 3 + searcher cycles (done in first WAIT cycle gives rsp 3 cycles after ready).
REQ-026 Requester deasserting valid after grant SHALL not affect the transaction.

Reset
REQ-027 cta_rst_n low SHALL asynchronously force IDLE, pointer = RX, counter 0, and all outputs 0, including mid-transaction; cta_rs_rq SHALL never stay nonzero during reset.
REQ-028 After deassertion, first grant SHALL be possible on the first rising edge with cta_rst_n high.

Verification
REQ-029 RX lookup alone, searcher done 2 cycles after rq with id 8'h05 error 0 -> ready[0] at T, rs_rq=01 at T+1, rsp_valid[0] with id 05 error 00 at T+4.
REQ-030 Both valid continuously after reset, searcher done immediately -> grants alternate RX, TX, RX, TX; each rs_rq single-cycle.
REQ-031 TX op 00 -> ready[1], no rs_rq activity, rsp_valid[1] with error FE two cycles later.
REQ-032 TIMEOUT=4, searcher never done -> rsp_valid with error FF, id 00 exactly 4 WAIT cycles after entry; spurious done in IDLE afterwards ignored.
REQ-033 cta_rst_n low during WAIT -> immediate busy=0, rs_rq=00, no rsp_valid; next request served normally with pointer at RX.

Source files
------------

// File: rtl/conn_table_arbiter.sv
// conn_table_arbiter: round-robin front end that lets the RX and TX paths share one
// connection-searcher port, with a single transaction in flight at a time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transaction; grant a requester when any valid is seen
// S_ISSUE | drive the latched op onto the searcher for exactly one cycle
// S_WAIT  | wait for searcher done, abort after TIMEOUT cycles
// S_RESP  | one-cycle response pulse to the granted requester
module conn_table_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         cta_clk,
    input  logic         cta_rst_n,
    input  logic [1:0]   cta_req_valid,
    input  logic [3:0]   cta_req_op,
    input  logic [287:0] cta_req_tuple,
    input  logic [15:0]  cta_req_id,
    output logic [1:0]   cta_req_ready,
    output logic [1:0]   cta_rsp_valid,
    output logic [7:0]   cta_rsp_id,
    output logic [7:0]   cta_rsp_error,
    output logic [1:0]   cta_rs_rq,
    output logic [7:0]   cta_rs_id,
    output logic [143:0] cta_rs_tuple,
    input  logic         cta_rs_done,
    input  logic [7:0]   cta_rs_error,
    input  logic [7:0]   cta_rs_id_in,
    output logic         cta_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  ERR_ILLEGAL = 8'hFE;
    localparam logic [7:0]  ERR_TIMEOUT = 8'hFF;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_ptr;
    logic           r_gnt;
    logic [1:0]     r_op;
    logic [143:0]   r_tuple;
    logic [7:0]     r_id;
    logic [15:0]    r_cnt;
    logic [7:0]     r_rsp_id;
    logic [7:0]     r_rsp_err;

    logic           w_grant;
    logic           w_sel;
    logic           w_timeout;
    logic [1:0]     w_sel_op;
    logic [143:0]   w_sel_tuple;
    logic [7:0]     w_sel_id;

    // Reset gating keeps the ready pulse quiet while the block is held in reset.
    always_comb begin
        w_grant = (r_state == S_IDLE) && (cta_req_valid != 2'b00) && cta_rst_n;
        if (cta_req_valid == 2'b11) begin
            w_sel = r_ptr;
        end else begin
            w_sel = cta_req_valid[1];
        end
        w_sel_op    = w_sel ? cta_req_op[3:2]        : cta_req_op[1:0];
        w_sel_tuple = w_sel ? cta_req_tuple[287:144] : cta_req_tuple[143:0];
        w_sel_id    = w_sel ? cta_req_id[15:8]       : cta_req_id[7:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = (r_op == 2'b00) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cta_rs_done) begin
                    w_state_nxt = S_RESP;
                end else if (r_cnt == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cta_clk or negedge cta_rst_n) begin
        if (!cta_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge cta_clk or negedge cta_rst_n) begin
        if (!cta_rst_n) begin
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            r_op    <= 2'b00;
            r_tuple <= '0;
            r_id    <= '0;
        end else if (w_grant) begin
            r_gnt   <= w_sel;
            r_ptr   <= ~w_sel;
            r_op    <= w_sel_op;
            r_tuple <= w_sel_tuple;
            r_id    <= w_sel_id;
        end
    end

    // Counter sits at zero outside WAIT, so it is already cleared on entry.
    always_ff @(posedge cta_clk or negedge cta_rst_n) begin
        if (!cta_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge cta_clk or negedge cta_rst_n) begin
        if (!cta_rst_n) begin
            r_rsp_id  <= '0;
            r_rsp_err <= '0;
        end else if ((r_state == S_ISSUE) && (r_op == 2'b00)) begin
            r_rsp_id  <= 8'h00;
            r_rsp_err <= ERR_ILLEGAL;
        end else if (r_state == S_WAIT) begin
            if (cta_rs_done) begin
                r_rsp_id  <= cta_rs_id_in;
                r_rsp_err <= cta_rs_error;
            end else if (w_timeout) begin
                r_rsp_id  <= 8'h00;
                r_rsp_err <= ERR_TIMEOUT;
            end
        end
    end

    always_comb begin
        cta_req_ready = 2'b00;
        if (w_grant) begin
            cta_req_ready = w_sel ? 2'b10 : 2'b01;
        end
        cta_rsp_valid = 2'b00;
        if (r_state == S_RESP) begin
            cta_rsp_valid = r_gnt ? 2'b10 : 2'b01;
        end
        cta_rs_rq     = (r_state == S_ISSUE) ? r_op : 2'b00;
        cta_rs_tuple  = r_tuple;
        cta_rs_id     = r_id;
        cta_rsp_id    = r_rsp_id;
        cta_rsp_error = r_rsp_err;
        cta_busy      = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_conn_table_arbiter.sv
// Bench for conn_table_arbiter: directed transaction table, reset corner cases,
// then randomized traffic against a cycle-number based transaction model.
module tb_conn_table_arbiter;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   valid = '0;
    logic [3:0]   op = '0;
    logic [287:0] tuple = '0;
    logic [15:0]  id = '0;
    logic [1:0]   ready;
    logic [1:0]   rsp_valid;
    logic [7:0]   rsp_id;
    logic [7:0]   rsp_err;
    logic [1:0]   rs_rq;
    logic [7:0]   rs_id;
    logic [143:0] rs_tuple;
    logic         rs_done = 1'b0;
    logic [7:0]   rs_error = '0;
    logic [7:0]   rs_id_in = '0;
    logic         busy;
    logic [1:0]   e_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conn_table_arbiter #(.TIMEOUT(TO)) dut (
        .cta_clk       (clk),
        .cta_rst_n     (rst_n),
        .cta_req_valid (valid),
        .cta_req_op    (op),
        .cta_req_tuple (tuple),
        .cta_req_id    (id),
        .cta_req_ready (ready),
        .cta_rsp_valid (rsp_valid),
        .cta_rsp_id    (rsp_id),
        .cta_rsp_error (rsp_err),
        .cta_rs_rq     (rs_rq),
        .cta_rs_id     (rs_id),
        .cta_rs_tuple  (rs_tuple),
        .cta_rs_done   (rs_done),
        .cta_rs_error  (rs_error),
        .cta_rs_id_in  (rs_id_in),
        .cta_busy      (busy)
    );

    typedef struct {
        logic [1:0] valid;
        logic [1:0] op_rx;
        logic [1:0] op_tx;
        int         k;          // WAIT cycle index in which searcher answers
        logic [7:0] did;
        logic [7:0] derr;
        logic [1:0] exp_ready;
        logic [1:0] exp_rq;
        int         exp_lat;    // cycles from ready to rsp_valid
        logic [7:0] exp_id;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [287:0] rand288();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called just after a falling edge while the DUT is idle; returns just after a falling edge.
    task automatic run_vec(input vec_t v, input string nm);
        logic [287:0] tup;
        logic [15:0]  ids;
        logic [143:0] exp_tup;
        logic [7:0]   exp_rid;
        int           lat;
        tup     = rand288();
        ids     = 16'($urandom);
        exp_tup = v.exp_ready[1] ? tup[287:144] : tup[143:0];
        exp_rid = v.exp_ready[1] ? ids[15:8] : ids[7:0];
        valid = v.valid; op = {v.op_tx, v.op_rx}; tuple = tup; id = ids; rs_done = 1'b0;
        #1;
        chk({nm, "_ready"}, 144'(ready), 144'(v.exp_ready));
        chk({nm, "_busy_idle"}, 144'(busy), 144'(1'b0));
        @(negedge clk);
        valid = 2'b11; op = 4'b0000; tuple = rand288(); id = 16'($urandom);
        #1;
        chk({nm, "_rs_rq"}, 144'(rs_rq), 144'(v.exp_rq));
        chk({nm, "_busy"}, 144'(busy), 144'(1'b1));
        chk({nm, "_ready_busy"}, 144'(ready), 144'(2'b00));
        chk({nm, "_rs_tuple"}, rs_tuple, exp_tup);
        chk({nm, "_rs_id"}, 144'(rs_id), 144'(exp_rid));
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 12) begin
            @(negedge clk);
            lat++;
            rs_done = (lat - 2 == v.k); rs_id_in = v.did; rs_error = v.derr;
            #1;
            chk({nm, "_rq_quiet"}, 144'(rs_rq), 144'(2'b00));
            chk({nm, "_no_regrant"}, 144'(ready), 144'(2'b00));
        end
        chk({nm, "_latency"}, 144'(lat), 144'(v.exp_lat));
        chk({nm, "_rsp_valid"}, 144'(rsp_valid), 144'(v.exp_ready));
        chk({nm, "_rsp_id"}, 144'(rsp_id), 144'(v.exp_id));
        chk({nm, "_rsp_err"}, 144'(rsp_err), 144'(v.exp_err));
        chk({nm, "_tuple_held"}, rs_tuple, exp_tup);
        @(negedge clk);
        valid = 2'b00; rs_done = 1'b0;
        #1;
        chk({nm, "_rsp_done"}, 144'(rsp_valid), 144'(2'b00));
        chk({nm, "_back_idle"}, 144'(busy), 144'(1'b0));
        chk({nm, "_rsp_id_hold"}, 144'(rsp_id), 144'(v.exp_id));
    endtask

    task automatic random_phase(input int ncyc);
        int n, m_gnt, m_rsp, m_done, k;
        bit m_act, m_ptr, m_g, g, in_wait, e_busy;
        logic [1:0]   m_op, e_rq, e_rspv;
        logic [143:0] m_tup;
        logic [7:0]   m_id, m_did, m_derr, m_pid, m_perr, e_rid, e_rerr;
        n = 0; m_act = 0; m_ptr = 0; m_g = 0; m_gnt = 0; m_rsp = 0; m_done = -1;
        m_op = 0; m_tup = 0; m_id = 0; m_did = 0; m_derr = 0; m_pid = 0; m_perr = 0;
        e_rid = 0; e_rerr = 0;
        for (int c = 0; c < ncyc; c++) begin
            in_wait = m_act && (n >= m_gnt + 2) && (n < m_rsp);
            if (m_act && n == m_done) begin
                rs_done = 1'b1; rs_id_in = m_did; rs_error = m_derr;
            end else if (!in_wait && $urandom_range(0, 3) == 0) begin
                rs_done = 1'b1; rs_id_in = 8'($urandom); rs_error = 8'($urandom);
            end else begin
                rs_done = 1'b0;
            end
            valid = 2'($urandom_range(0, 3)); op = 4'($urandom);
            tuple = rand288(); id = 16'($urandom);
            #1;
            e_busy = m_act; e_ready = 2'b00; e_rq = 2'b00; e_rspv = 2'b00;
            if (!m_act && valid != 2'b00) begin
                if (valid == 2'b11) g = m_ptr;
                else g = (valid == 2'b10);
                m_ptr = !g; m_g = g; m_act = 1; m_gnt = n;
                m_op  = g ? op[3:2] : op[1:0];
                m_tup = g ? tuple[287:144] : tuple[143:0];
                m_id  = g ? id[15:8] : id[7:0];
                e_ready = g ? 2'b10 : 2'b01;
                k = $urandom_range(0, 5);
                m_did = 8'($urandom); m_derr = 8'($urandom);
                if (m_op == 2'b00) begin
                    m_done = -1; m_rsp = n + 2; m_pid = 8'h00; m_perr = 8'hFE;
                end else if (k < TO) begin
                    m_done = n + 2 + k; m_rsp = n + 3 + k; m_pid = m_did; m_perr = m_derr;
                end else begin
                    m_done = -1; m_rsp = n + 2 + TO; m_pid = 8'h00; m_perr = 8'hFF;
                end
            end
            if (m_act && n == m_gnt + 1) e_rq = m_op;
            if (m_act && n == m_rsp) begin
                e_rspv = m_g ? 2'b10 : 2'b01; e_rid = m_pid; e_rerr = m_perr;
            end
            chk("rnd_ready", 144'(ready), 144'(e_ready));
            chk("rnd_busy", 144'(busy), 144'(e_busy));
            chk("rnd_rs_rq", 144'(rs_rq), 144'(e_rq));
            chk("rnd_rsp_valid", 144'(rsp_valid), 144'(e_rspv));
            chk("rnd_rsp_id", 144'(rsp_id), 144'(e_rid));
            chk("rnd_rsp_err", 144'(rsp_err), 144'(e_rerr));
            if (m_act && n > m_gnt) begin
                chk("rnd_rs_tuple", rs_tuple, m_tup);
                chk("rnd_rs_id", 144'(rs_id), 144'(m_id));
            end
            if (m_act && n == m_rsp) m_act = 0;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        //           valid  rx     tx     k  did    derr   ready  rq     lat id     err
        vecs[0] = '{2'b01, 2'b01, 2'b00, 1, 8'h05, 8'h00, 2'b01, 2'b01, 4, 8'h05, 8'h00};
        vecs[1] = '{2'b11, 2'b10, 2'b11, 0, 8'h11, 8'h00, 2'b10, 2'b11, 3, 8'h11, 8'h00};
        vecs[2] = '{2'b11, 2'b01, 2'b01, 0, 8'h22, 8'h03, 2'b01, 2'b01, 3, 8'h22, 8'h03};
        vecs[3] = '{2'b11, 2'b10, 2'b10, 2, 8'h33, 8'h00, 2'b10, 2'b10, 5, 8'h33, 8'h00};
        vecs[4] = '{2'b10, 2'b01, 2'b00, 9, 8'h77, 8'h77, 2'b10, 2'b00, 2, 8'h00, 8'hFE};
        vecs[5] = '{2'b01, 2'b11, 2'b01, 3, 8'h44, 8'h00, 2'b01, 2'b11, 6, 8'h44, 8'h00};
        vecs[6] = '{2'b01, 2'b01, 2'b10, 0, 8'h7A, 8'h01, 2'b01, 2'b01, 3, 8'h7A, 8'h01};
        vecs[7] = '{2'b01, 2'b01, 2'b00, 9, 8'h88, 8'h88, 2'b01, 2'b01, 6, 8'h00, 8'hFF};
        vecs[8] = '{2'b11, 2'b10, 2'b01, 0, 8'h5A, 8'h00, 2'b01, 2'b10, 3, 8'h5A, 8'h00};

        // Held in reset with both requesters asking: nothing may come out.
        valid = 2'b11; op = 4'b0101;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 144'(ready), 144'(2'b00));
        chk("rst_busy", 144'(busy), 144'(1'b0));
        chk("rst_rs_rq", 144'(rs_rq), 144'(2'b00));
        chk("rst_rsp_valid", 144'(rsp_valid), 144'(2'b00));
        chk("rst_rsp_id", 144'(rsp_id), 144'(8'h00));
        chk("rst_rsp_err", 144'(rsp_err), 144'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Spurious searcher done while idle after a timeout must change nothing.
        @(negedge clk);
        rs_done = 1'b1; rs_id_in = 8'h99; rs_error = 8'h55; valid = 2'b00;
        repeat (3) begin
            #1;
            chk("spur_busy", 144'(busy), 144'(1'b0));
            chk("spur_rsp_valid", 144'(rsp_valid), 144'(2'b00));
            chk("spur_rsp_id", 144'(rsp_id), 144'(8'h00));
            chk("spur_rsp_err", 144'(rsp_err), 144'(8'hFF));
            @(negedge clk);
        end
        rs_done = 1'b0;

        // Reset asserted mid-WAIT after an RX grant (pointer would otherwise be TX).
        valid = 2'b01; op = 4'b0001; tuple = rand288(); id = 16'h00AB;
        #1;
        chk("rw_ready", 144'(ready), 144'(2'b01));
        @(negedge clk);
        valid = 2'b11;
        #1;
        chk("rw_rs_rq", 144'(rs_rq), 144'(2'b01));
        @(negedge clk);
        #1;
        chk("rw_busy_wait", 144'(busy), 144'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        chk("rw_busy", 144'(busy), 144'(1'b0));
        chk("rw_rq", 144'(rs_rq), 144'(2'b00));
        chk("rw_rsp_valid", 144'(rsp_valid), 144'(2'b00));
        chk("rw_ready_rst", 144'(ready), 144'(2'b00));
        chk("rw_rsp_err", 144'(rsp_err), 144'(8'h00));
        chk("rw_rs_tuple", rs_tuple, 144'h0);
        repeat (2) begin
            @(negedge clk);
            rs_done = 1'b1; rs_id_in = 8'h66;
            #1;
            chk("rw_hold_rsp", 144'(rsp_valid), 144'(2'b00));
            chk("rw_hold_busy", 144'(busy), 144'(1'b0));
        end
        @(negedge clk);
        rs_done = 1'b0; rst_n = 1'b1;
        run_vec(vecs[8], "post_rst");

        // Fresh reset so the model starts from a known pointer and response hold.
        @(negedge clk);
        rst_n = 1'b0; valid = 2'b00; rs_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        random_phase(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
